tetromino_bag_queue: RTL and testbench

//  Parametrised successor to the single-LFSR piece generator. Produces the spawn

---
 rtl/tetromino_bag_queue_if.sv | 27 ++
 rtl/tetromino_bag_queue.sv | 128 ++++++++++++
 tb/tb_tetromino_bag_queue.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/tetromino_bag_queue_if.sv
// Handshake bundle between game control / preview renderer and the
// tetromino bag queue. Game control owns pop and the seeding inputs;
// the queue owns the head and preview outputs.
interface tetromino_bag_queue_if #(
  parameter int LFSR_W        = 16,
  parameter int PREVIEW_DEPTH = 3
);
  logic                       pop;
  logic                       seed_load;
  logic [LFSR_W-1:0]          seed_value;
  logic                       head_valid;
  logic [2:0]                 head_idx;
  logic signed [5:0]          head_x;
  logic signed [5:0]          head_y;
  logic [3*PREVIEW_DEPTH-1:0] preview_idx;
  logic [PREVIEW_DEPTH-1:0]   preview_valid;

  modport master (
    output pop, seed_load, seed_value,
    input  head_valid, head_idx, head_x, head_y, preview_idx, preview_valid
  );

  modport slave (
    input  pop, seed_load, seed_value,
    output head_valid, head_idx, head_x, head_y, preview_idx, preview_valid
  );
endinterface

// File: rtl/tetromino_bag_queue.sv
// Tetromino generator with a look-ahead queue. An XNOR LFSR supplies a
// random value every cycle; each time the queue has a free slot a piece is
// drawn (7-bag or plain mod-7) and appended behind the head.
`ifndef TETROMINO_I_IDX
`define TETROMINO_I_IDX 3'd0
`endif

module tetromino_bag_queue #(
  parameter int                LFSR_W        = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS     = 16'hD008,
  parameter logic [LFSR_W-1:0] SEED          = 16'd4425,
  parameter int                PREVIEW_DEPTH = 3,
  parameter bit                BAG_MODE      = 1'b1
) (
  input logic                   clk,
  input logic                   reset,
  tetromino_bag_queue_if.slave  bus
);

  localparam int DEPTH = PREVIEW_DEPTH + 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [LFSR_W-1:0]        lfsr_q, lfsr_d;
  logic [6:0]               mask_q, mask_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [2:0]               slot_q [DEPTH];
  logic [2:0]               slot_d [DEPTH];
  logic                     head_valid_q, head_valid_d;
  logic [PREVIEW_DEPTH-1:0] preview_valid_q, preview_valid_d;

  logic [LFSR_W-1:0]        lfsr_mod7;
  logic [2:0]               draw_r;
  logic [2:0]               draw_piece;
  logic [3:0]               cand;
  logic [6:0]               mask_used;
  logic [CNT_W-1:0]         fill_count;

  // Draw a piece from the current LFSR value; in bag mode probe forward from
  // r for the first piece still in the bag (lowest offset wins).
  always_comb begin
    lfsr_mod7  = lfsr_q % LFSR_W'(7);
    draw_r     = lfsr_mod7[2:0];
    draw_piece = draw_r;
    cand       = 4'd0;
    if (BAG_MODE) begin
      for (int i = 6; i >= 0; i--) begin
        cand = {1'b0, draw_r} + 4'(i);
        if (cand >= 4'd7) begin
          cand = cand - 4'd7;
        end
        if (mask_q[cand[2:0]]) begin
          draw_piece = cand[2:0];
        end
      end
    end
    mask_used = mask_q & ~(7'd1 << draw_piece);
  end

  // Next state: LFSR step, pop-shift toward the head, then append into the
  // first free slot so a full queue stays full across a pop.
  always_comb begin
    lfsr_d     = {lfsr_q[LFSR_W-2:0], ~^(lfsr_q & LFSR_TAPS)};
    mask_d     = mask_q;
    slot_d     = slot_q;
    fill_count = count_q;
    if (bus.pop && (count_q != '0)) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        slot_d[i] = slot_q[i+1];
      end
      slot_d[DEPTH-1] = 3'd0;
      fill_count      = count_q - CNT_W'(1);
    end
    count_d = fill_count;
    if (fill_count < CNT_W'(DEPTH)) begin
      slot_d[fill_count] = draw_piece;
      count_d            = fill_count + CNT_W'(1);
      if (BAG_MODE) begin
        mask_d = (mask_used == 7'd0) ? 7'h7F : mask_used;
      end
    end
    head_valid_d = (count_d != '0);
    for (int k = 0; k < PREVIEW_DEPTH; k++) begin
      preview_valid_d[k] = (count_d > CNT_W'(k + 1));
    end
  end

  // State register; reset beats seed_load, and an all-ones seed would lock
  // the XNOR LFSR so it is swapped for the default seed.
  always_ff @(posedge clk) begin
    if (reset || bus.seed_load) begin
      if (reset || (&bus.seed_value)) begin
        lfsr_q <= SEED;
      end else begin
        lfsr_q <= bus.seed_value;
      end
      mask_q          <= 7'h7F;
      count_q         <= '0;
      head_valid_q    <= 1'b0;
      preview_valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_q[i] <= 3'd0;
      end
    end else begin
      lfsr_q          <= lfsr_d;
      mask_q          <= mask_d;
      count_q         <= count_d;
      head_valid_q    <= head_valid_d;
      preview_valid_q <= preview_valid_d;
      for (int i = 0; i < DEPTH; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

  // Drive the bus from the registered queue; spawn position decodes the head.
  always_comb begin
    bus.head_valid    = head_valid_q;
    bus.head_idx      = slot_q[0];
    bus.preview_valid = preview_valid_q;
    bus.preview_idx   = '0;
    for (int k = 0; k < PREVIEW_DEPTH; k++) begin
      bus.preview_idx[3*k +: 3] = slot_q[k+1];
    end
    bus.head_x = 6'sd3;
    bus.head_y = (slot_q[0] == `TETROMINO_I_IDX) ? 6'sd0 : -6'sd1;
  end

endmodule

// File: tb/tb_tetromino_bag_queue.sv
// Scoreboard bench for tetromino_bag_queue: one bag-mode and one
// random-mode instance share stimulus; a queue-based reference model
// predicts each post-edge state and a negedge monitor compares.
module tb_tetromino_bag_queue;

  localparam logic [15:0] SEED_DEF = 16'd4425;
  localparam logic [15:0] TAPS     = 16'hD008;
  localparam int          DEPTH    = 4;
  localparam int          I_IDX    = 0;

  typedef struct packed {
    logic [1:0]  hv;
    logic [5:0]  head;
    logic [5:0]  pv;
    logic [17:0] prev;
  } exp_t;

  logic clk;
  logic reset;

  tetromino_bag_queue_if #(.LFSR_W(16), .PREVIEW_DEPTH(3)) bus_bag ();
  tetromino_bag_queue_if #(.LFSR_W(16), .PREVIEW_DEPTH(3)) bus_rnd ();

  tetromino_bag_queue #(.BAG_MODE(1'b1)) dut_bag (.clk(clk), .reset(reset), .bus(bus_bag));
  tetromino_bag_queue #(.BAG_MODE(1'b0)) dut_rnd (.clk(clk), .reset(reset), .bus(bus_rnd));

  int n_vectors     = 0;
  int n_miscompares = 0;

  exp_t        exp_q[$];
  logic [15:0] m_lfsr [2];
  logic [6:0]  m_bag  [2];
  int          m_q0[$];
  int          m_q1[$];
  int          bag_seen[$];
  bit          record_bag = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic compareField(input string name, input int mode, input int act, input int expv);
    n_vectors++;
    if (act != expv) begin
      n_miscompares++;
      $display("[TB] FAIL %s mode%0d @%0t: got %0d expected %0d", name, mode, $time, act, expv);
    end
  endtask

  function automatic logic [15:0] lfsrNext(input logic [15:0] l);
    logic fb;
    fb = ($countones(l & TAPS) % 2 == 0);
    return {l[14:0], fb};
  endfunction

  // Sequence-level model: a FIFO of piece numbers plus a bag of unused pieces.
  task automatic modelStep(input int mode, input bit rst, input bit sl, input bit pp,
                           input logic [15:0] sv);
    int q[$];
    logic [15:0] l;
    logic [6:0] bag;
    int r, piece, p;
    bit found;
    if (mode == 1) q = m_q1; else q = m_q0;
    l   = m_lfsr[mode];
    bag = m_bag[mode];
    if (rst || sl) begin
      l = (rst || sv == 16'hFFFF) ? SEED_DEF : sv;
      q.delete();
      bag = 7'h7F;
    end else begin
      if (pp && q.size() > 0) void'(q.pop_front());
      if (q.size() < DEPTH) begin
        r = int'(l) % 7;
        piece = r;
        if (mode == 1) begin
          found = 0;
          for (int k = 0; k < 7; k++) begin
            p = (r + k) % 7;
            if (!found && bag[p]) begin
              piece = p;
              found = 1;
            end
          end
          bag[piece] = 1'b0;
          if (bag == 7'd0) bag = 7'h7F;
        end
        q.push_back(piece);
      end
      l = lfsrNext(l);
    end
    if (mode == 1) m_q1 = q; else m_q0 = q;
    m_lfsr[mode] = l;
    m_bag[mode]  = bag;
  endtask

  function automatic void fillExp(input int mode, inout exp_t e);
    int q[$];
    if (mode == 1) q = m_q1; else q = m_q0;
    e.hv[mode] = (q.size() > 0);
    e.head[3*mode +: 3] = (q.size() > 0) ? 3'(q[0]) : 3'd0;
    for (int k = 0; k < 3; k++) begin
      e.pv[3*mode + k] = (q.size() > k + 1);
      e.prev[9*mode + 3*k +: 3] = (q.size() > k + 1) ? 3'(q[k+1]) : 3'd0;
    end
  endfunction

  // Drive one cycle of inputs, then record what both instances must show.
  task automatic applyStimulus(input bit rst, input bit sl, input bit pp, input logic [15:0] sv);
    exp_t e;
    if (record_bag && pp && !rst && !sl && bus_bag.head_valid)
      bag_seen.push_back(int'(bus_bag.head_idx));
    reset = rst;
    bus_bag.seed_load = sl;  bus_rnd.seed_load = sl;
    bus_bag.seed_value = sv; bus_rnd.seed_value = sv;
    bus_bag.pop = pp;        bus_rnd.pop = pp;
    @(posedge clk);
    modelStep(1, rst, sl, pp, sv);
    modelStep(0, rst, sl, pp, sv);
    e = '0;
    fillExp(1, e);
    fillExp(0, e);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic checkOutput(input int mode, input exp_t e);
    logic hv;
    logic [2:0] hi, pv;
    logic [8:0] pi;
    logic signed [5:0] hx, hy;
    int eh;
    if (mode == 1) begin
      hv = bus_bag.head_valid; hi = bus_bag.head_idx; pv = bus_bag.preview_valid;
      pi = bus_bag.preview_idx; hx = bus_bag.head_x; hy = bus_bag.head_y;
    end else begin
      hv = bus_rnd.head_valid; hi = bus_rnd.head_idx; pv = bus_rnd.preview_valid;
      pi = bus_rnd.preview_idx; hx = bus_rnd.head_x; hy = bus_rnd.head_y;
    end
    eh = int'(e.head[3*mode +: 3]);
    compareField("head_valid", mode, int'(hv), int'(e.hv[mode]));
    compareField("head_idx", mode, int'(hi), eh);
    compareField("preview_valid", mode, int'(pv), int'(e.pv[3*mode +: 3]));
    for (int k = 0; k < 3; k++) begin
      if (e.pv[3*mode + k])
        compareField("preview_idx", mode, int'(pi[3*k +: 3]), int'(e.prev[9*mode + 3*k +: 3]));
    end
    compareField("head_x", mode, int'(hx), 3);
    compareField("head_y", mode, int'(hy), (eh == I_IDX) ? 0 : -1);
  endtask

  // Monitor: one expected snapshot per active edge, checked on the next negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(1, e);
        checkOutput(0, e);
      end
    end
  end

  initial begin
    logic [6:0] grp;
    int last_pos [7];
    int max_gap;
    bit rst, sl, pp;
    logic [15:0] sv;

    reset = 1'b1;
    bus_bag.pop = 1'b0; bus_rnd.pop = 1'b0;
    bus_bag.seed_load = 1'b0; bus_rnd.seed_load = 1'b0;
    bus_bag.seed_value = '0; bus_rnd.seed_value = '0;
    for (int m = 0; m < 2; m++) begin
      m_lfsr[m] = SEED_DEF;
      m_bag[m]  = 7'h7F;
    end

    $display("[TB] reset and fill from empty");
    applyStimulus(1, 0, 0, 16'h0);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 16'h0);

    $display("[TB] pop right after reset, then full-queue pops");
    applyStimulus(1, 0, 0, 16'h0);
    applyStimulus(0, 0, 1, 16'h0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 16'h0);
    applyStimulus(0, 0, 1, 16'h0);
    applyStimulus(0, 0, 0, 16'h0);

    $display("[TB] bag permutation run");
    applyStimulus(1, 0, 0, 16'h0);
    bag_seen.delete();
    record_bag = 1;
    for (int i = 0; i < 705; i++) applyStimulus(0, 0, 1, 16'h0);
    record_bag = 0;
    for (int g = 0; g + 7 <= bag_seen.size() && g < 700; g += 7) begin
      grp = 7'd0;
      for (int j = 0; j < 7; j++) grp[bag_seen[g+j]] = 1'b1;
      compareField("bag_group", 1, int'(grp), 7'h7F);
    end
    max_gap = 0;
    for (int p = 0; p < 7; p++) last_pos[p] = -1;
    for (int i = 0; i < bag_seen.size(); i++) begin
      if (i - last_pos[bag_seen[i]] - 1 > max_gap) max_gap = i - last_pos[bag_seen[i]] - 1;
      last_pos[bag_seen[i]] = i;
    end
    compareField("bag_max_gap_le12", 1, int'(max_gap <= 12), 1);

    $display("[TB] seed_load checks");
    applyStimulus(0, 1, 0, 16'hFFFF);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, i[0], 16'h0);
    applyStimulus(1, 1, 0, 16'h1234);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 1, 16'h0);
    applyStimulus(0, 1, 0, 16'hBEEF);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 1, 16'h0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      sl  = ($urandom_range(0, 49) == 0);
      pp  = ($urandom_range(0, 3) != 0);
      sv  = ($urandom_range(0, 2) == 0) ? 16'hFFFF : 16'($urandom);
      applyStimulus(rst, sl, pp, sv);
    end

    @(negedge clk);
    @(negedge clk);
    compareField("scoreboard_drained", 0, exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
